fpu_issue: RTL and testbench
============================

Name: fpu_issue

Overview:
- Issue/retire stage directly upstream of the fpu block.
- Accepts one floating-point operation per transaction from the execute stage over a valid/ready handshake. Registers the operands, waits for fpu idle, then pulses fpu en for exactly one cycle.
- Captures the fpu result on its first valid cycle and holds it, with its destination tag, until writeback accepts it.
- At most one operation is in flight.

Parameters:
- TAG_W, 6, width of destination-register tag carried alongside the operation
- DATA_W, 32, operand/result width (fixed 32 for fpu compatibility)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  operation offered by execute stage
- req_ready  out  1  stage can accept an operation
- req_funct  in  5  fpu function code
- req_x1  in  DATA_W  operand 1
- req_x2  in  DATA_W  operand 2 (sqrt/ftoi/itof source)
- req_tag  in  TAG_W  destination tag
- fpu_funct  out  5  function code to fpu
- fpu_x1  out  DATA_W  operand 1 to fpu
- fpu_x2  out  DATA_W  operand 2 to fpu
- fpu_en  out  1  one-cycle start pulse to fpu
- fpu_y  in  DATA_W  fpu result
- fpu_valid  in  1  fpu result valid
- fpu_idle  in  1  all fpu units idle
- res_valid  out  1  result available to writeback
- res_ready  in  1  writeback accepts result
- res_data  out  DATA_W  result
- res_tag  out  TAG_W  destination tag of result
- res_err  out  1  op had an unsupported function code; res_data is 0

Behaviour:
- Single clock clk; rstn is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - req_ready=1 (combinational from IDLE)
  - fpu_en=0, res_valid=0, res_err=0
  - res_data=0, res_tag=0
  - operand/funct registers = 0
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture funct/x1/x2/tag into registers and go to ISSUE.
- ISSUE:
  - fpu_funct/x1/x2 are driven from registers and are held stable in ISSUE and WAIT.
  - If the registered funct is unsupported, go to DONE with res_err=1 and res_data=0. fpu_en is never pulsed.
  - Unsupported means: funct[4]=1 with funct[3:1]=000, or funct[4:0]=00000.
  - Otherwise, if fpu_idle=1: fpu_en=1 for this cycle only, go to WAIT.
  - If fpu_idle=0: stay in ISSUE with fpu_en=0.
- WAIT:
  - fpu_valid is ignored until the cycle after the fpu_en cycle.
  - The first cycle with fpu_valid=1 captures fpu_y into res_data and sets res_err=0; go to DONE.
  - Multi-cycle high valid is harmless; only the first valid cycle is captured.
- DONE:
  - res_valid=1; res_data/res_tag/res_err are held stable.
  - When res_ready=1, go to IDLE next cycle.
  - req_ready=0 in DONE: no same-cycle turnaround.
- Minimum latency (fpu idle, fpu valid N cycles after en): req handshake at cycle 0, fpu_en at cycle 1, res_valid at cycle N+2.
- Throughput: one op per N+3 cycles minimum.
- Boundary conditions:
  - res_ready high outside DONE: ignored.
  - req_valid outside IDLE: ignored, not captured.
  - rstn low mid-operation (any state): returns immediately to IDLE with all outputs at reset values. Any result the fpu produces later is ignored, because WAIT is no longer active.

Optional Feature:
- Macro: FPU_ISSUE_CMP_EN.
- Defined:
  - funct[4]=1 with funct[3:1]=000 is supported and executed locally, without the fpu.
  - funct[0]=1 is fless: res_data=1 if x1<x2, else 0.
  - funct[0]=0 is feq: res_data=1 if x1==x2, else 0.
  - +0 and -0 compare equal; NaN is not supported.
  - ISSUE goes directly to DONE with res_err=0. Result latency is 2 cycles after the req handshake.
- Undefined: those codes are unsupported and complete with res_err=1, as above.

Decomposition:
- Package fpu_issue_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - funct field localparams (F_ADD, F_SUB, F_MUL, F_DIV, F_SQRT, F_FTOI, F_ITOF, F_FEQ, F_FLESS)
  - is_supported() function
- Sub-module fcmp: combinational feq/fless, instantiated only under FPU_ISSUE_CMP_EN.

Test Plan:
- fadd (funct=00001), x1=0x3F800000, x2=0x40000000; fpu model valid 2 cycles after en, y=0x40400000:
  - fpu_en pulses exactly once at cycle 1.
  - res_valid at cycle 4 with res_data=0x40400000 and the tag echoed.
- fpu_idle held low 5 cycles after the handshake:
  - fpu_en stays 0 and fpu_x1/x2 stay stable.
  - en pulses in the first cycle idle=1.
- res_ready held low 10 cycles in DONE with req_valid=1 throughout:
  - res_data, res_tag and res_err held stable; req_ready=0 and no new capture.
  - Next op is accepted in the cycle after the res_ready handshake.
- funct=10000 without the macro:
  - No fpu_en.
  - res_valid at cycle 2 with res_err=1 and res_data=0.
- funct=10000 with FPU_ISSUE_CMP_EN, x1=x2=0x80000000 vs 0x00000000: res_data=1 (feq), res_err=0.
- funct=10001 with FPU_ISSUE_CMP_EN, x1=0xBF800000, x2=0x3F800000: res_data=1 (fless).
- rstn asserted in WAIT, fpu valid arrives 1 cycle later:
  - All outputs are at reset values and res_valid stays 0.
  - Next op completes normally.

Source files
------------

// File: rtl/fpu_issue_pkg.sv
// -----------------------------------------------------------------------------
// fpu_issue_pkg
//   Shared types and helpers for the fpu issue/retire stage.
//   - state_e       : issue FSM states
//   - F_*           : fpu function codes
//   - is_cmp()      : code is a local compare (feq/fless)
//   - is_supported(): code may complete without an error
//   Optional feature macro: FPU_ISSUE_CMP_EN (compare codes run locally).
// -----------------------------------------------------------------------------
package fpu_issue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [4:0] F_ADD   = 5'b00001;
    localparam logic [4:0] F_SUB   = 5'b00010;
    localparam logic [4:0] F_MUL   = 5'b00011;
    localparam logic [4:0] F_DIV   = 5'b00100;
    localparam logic [4:0] F_SQRT  = 5'b00101;
    localparam logic [4:0] F_FTOI  = 5'b00110;
    localparam logic [4:0] F_ITOF  = 5'b00111;
    localparam logic [4:0] F_FEQ   = 5'b10000;
    localparam logic [4:0] F_FLESS = 5'b10001;

    // Compare codes: funct[4]=1 with funct[3:1]=000, funct[0] selects fless.
    function automatic logic is_cmp(input logic [4:0] funct);
        return funct[4] && (funct[3:1] == 3'b000);
    endfunction

    // All-zero is never a valid op; compare codes are only valid when the
    // local comparator is built in.
    function automatic logic is_supported(input logic [4:0] funct);
`ifdef FPU_ISSUE_CMP_EN
        return funct != 5'b00000;
`else
        return (funct != 5'b00000) && !is_cmp(funct);
`endif
    endfunction

endpackage

// File: rtl/fpu_issue_fcmp.sv
// -----------------------------------------------------------------------------
// fpu_issue_fcmp
//   Combinational single-precision compare used for feq/fless when the
//   FPU_ISSUE_CMP_EN macro is defined (the module only exists in that build).
//   NaN inputs are not supported; +0 and -0 compare equal.
//   Ports:
//     a_i, b_i : operands (IEEE-754 bit patterns)
//     less_i   : 1 = fless (a<b), 0 = feq (a==b)
//     res_o    : comparison result
// -----------------------------------------------------------------------------
`ifdef FPU_ISSUE_CMP_EN
module fpu_issue_fcmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              less_i,
    output logic              res_o
);

    logic              sign_a;
    logic              sign_b;
    logic [DATA_W-2:0] mag_a;
    logic [DATA_W-2:0] mag_b;
    logic              both_zero;
    logic              eq;
    logic              lt;

    assign sign_a    = a_i[DATA_W-1];
    assign sign_b    = b_i[DATA_W-1];
    assign mag_a     = a_i[DATA_W-2:0];
    assign mag_b     = b_i[DATA_W-2:0];
    assign both_zero = (mag_a == '0) && (mag_b == '0);
    assign eq        = both_zero || (a_i == b_i);

    // Sign-magnitude ordering: magnitude bits order like unsigned integers,
    // reversed when both operands are negative.
    always_comb begin
        lt = 1'b0;
        if (both_zero) begin
            lt = 1'b0;
        end else if (sign_a != sign_b) begin
            lt = sign_a;
        end else if (!sign_a) begin
            lt = mag_a < mag_b;
        end else begin
            lt = mag_a > mag_b;
        end
    end

    assign res_o = less_i ? lt : eq;

endmodule
`endif

// File: rtl/fpu_issue.sv
// -----------------------------------------------------------------------------
// fpu_issue
//   Issue/retire stage in front of the fpu. Accepts one operation at a time,
//   registers it, waits for the fpu to be idle, pulses fpu_en for one cycle,
//   captures the first valid fpu result and holds it (with its tag) until
//   writeback takes it. Unsupported function codes complete with res_err=1
//   and res_data=0 without touching the fpu.
//   Optional feature macro: FPU_ISSUE_CMP_EN -- feq/fless are executed locally.
//   Ports:
//     clk, rstn                        clock, async active-low reset
//     req_valid/req_ready              request handshake from execute stage
//     req_funct/req_x1/req_x2/req_tag  operation payload
//     fpu_funct/fpu_x1/fpu_x2/fpu_en   operation and start pulse to the fpu
//     fpu_y/fpu_valid/fpu_idle         fpu result and status
//     res_valid/res_ready              result handshake to writeback
//     res_data/res_tag/res_err         result payload
// -----------------------------------------------------------------------------
module fpu_issue
    import fpu_issue_pkg::*;
#(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    // execute-stage request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_funct,
    input  logic [DATA_W-1:0] req_x1,
    input  logic [DATA_W-1:0] req_x2,
    input  logic [TAG_W-1:0]  req_tag,
    // fpu interface
    output logic [4:0]        fpu_funct,
    output logic [DATA_W-1:0] fpu_x1,
    output logic [DATA_W-1:0] fpu_x2,
    output logic              fpu_en,
    input  logic [DATA_W-1:0] fpu_y,
    input  logic              fpu_valid,
    input  logic              fpu_idle,
    // writeback result
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_err
);

    state_e            state_q,    state_d;
    logic [4:0]        funct_q,    funct_d;
    logic [DATA_W-1:0] x1_q,       x1_d;
    logic [DATA_W-1:0] x2_q,       x2_d;
    logic [TAG_W-1:0]  tag_q,      tag_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_err_q,  res_err_d;

`ifdef FPU_ISSUE_CMP_EN
    logic cmp_res;

    fpu_issue_fcmp #(
        .DATA_W (DATA_W)
    ) u_fcmp (
        .a_i    (x1_q),
        .b_i    (x2_q),
        .less_i (funct_q[0]),
        .res_o  (cmp_res)
    );
`endif

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        funct_d    = funct_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        tag_d      = tag_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        req_ready  = 1'b0;
        fpu_en     = 1'b0;
        res_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct_d = req_funct;
                    x1_d    = req_x1;
                    x2_d    = req_x2;
                    tag_d   = req_tag;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (!is_supported(funct_q)) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = DONE;
`ifdef FPU_ISSUE_CMP_EN
                end else if (is_cmp(funct_q)) begin
                    res_data_d = {{(DATA_W-1){1'b0}}, cmp_res};
                    res_err_d  = 1'b0;
                    state_d    = DONE;
`endif
                end else if (fpu_idle) begin
                    // Leaving ISSUE in the same cycle guarantees a single pulse.
                    fpu_en  = 1'b1;
                    state_d = WAIT;
                end
            end

            // WAIT is first entered the cycle after fpu_en, so any fpu_valid
            // seen here belongs to this operation.
            WAIT: begin
                if (fpu_valid) begin
                    res_data_d = fpu_y;
                    res_err_d  = 1'b0;
                    state_d    = DONE;
                end
            end

            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            funct_q    <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            tag_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct_q    <= funct_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            tag_q      <= tag_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // Operand registers only load in IDLE, so the fpu sees stable values
    // for the whole of ISSUE and WAIT.
    assign fpu_funct = funct_q;
    assign fpu_x1    = x1_q;
    assign fpu_x2    = x2_q;
    assign res_data  = res_data_q;
    assign res_tag   = tag_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_fpu_issue.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue
//   Self-checking bench for fpu_issue. A reference model derives, for each
//   operation, the expected result, error flag, fpu_en cycle and result cycle
//   (cycle 0 = request handshake). A stub fpu answers lat cycles after fpu_en
//   and keeps fpu_valid high one extra cycle with a different value.
//   Build with +define+FPU_ISSUE_CMP_EN to exercise the local compare.
// -----------------------------------------------------------------------------
module tb_fpu_issue;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_funct;
    logic [DATA_W-1:0] req_x1;
    logic [DATA_W-1:0] req_x2;
    logic [TAG_W-1:0]  req_tag;
    logic [4:0]        fpu_funct;
    logic [DATA_W-1:0] fpu_x1;
    logic [DATA_W-1:0] fpu_x2;
    logic              fpu_en;
    logic [DATA_W-1:0] fpu_y;
    logic              fpu_valid;
    logic              fpu_idle;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;

    int n_checks = 0;
    int n_errors = 0;

    fpu_issue #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_funct (req_funct),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .req_tag   (req_tag),
        .fpu_funct (fpu_funct),
        .fpu_x1    (fpu_x1),
        .fpu_x2    (fpu_x2),
        .fpu_en    (fpu_en),
        .fpu_y     (fpu_y),
        .fpu_valid (fpu_valid),
        .fpu_idle  (fpu_idle),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Arbitrary but deterministic stand-in for the fpu's arithmetic.
    function automatic logic [31:0] fpu_stub(input logic [4:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        return (a + (b << 1)) ^ {27'd0, f} ^ 32'h5A5A_0000;
    endfunction

    // Float bit pattern -> signed integer with the same ordering (no NaN).
    function automatic longint fval(input logic [31:0] v);
        longint m;
        m = longint'(v[30:0]);
        return v[31] ? -m : m;
    endfunction

    function automatic void ref_model(input logic [4:0] f, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] d,
                                      output logic e, output bit local_op);
        bit cmp_code;
        cmp_code = (f[4] == 1'b1) && (f[3:1] == 3'b000);
`ifdef FPU_ISSUE_CMP_EN
        local_op = cmp_code;
`else
        local_op = 1'b0;
`endif
        if (f == 5'd0 || (cmp_code && !local_op)) begin
            d = 32'd0;
            e = 1'b1;
        end else if (local_op) begin
            e = 1'b0;
            if (f[0]) d = (fval(a) < fval(b)) ? 32'd1 : 32'd0;
            else      d = (fval(a) == fval(b)) ? 32'd1 : 32'd0;
        end else begin
            d = fpu_stub(f, a, b);
            e = 1'b0;
        end
    endfunction

    // Runs one operation starting just after a rising edge with the DUT idle.
    // idle_lo: cycles after the handshake with fpu_idle=0; lat: fpu latency
    // after fpu_en; hold: cycles res_ready stays low once res_valid is up.
    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] t, input int idle_lo, input int lat,
                          input int hold);
        logic [31:0] exp_d;
        logic        exp_e;
        bit          is_local;
        logic [31:0] y;
        int          exp_en;
        int          exp_done;
        int          last;

        ref_model(f, a, b, exp_d, exp_e, is_local);
        y = fpu_stub(f, a, b);
        if (exp_e || is_local) begin
            exp_en   = -1;
            exp_done = 2;
        end else begin
            exp_en   = idle_lo + 1;
            exp_done = exp_en + lat + 1;
        end
        last = exp_done + hold;

        req_valid = 1'b1;
        req_funct = f;
        req_x1    = a;
        req_x2    = b;
        req_tag   = t;
        fpu_idle  = 1'($urandom);
        fpu_valid = 1'b0;
        fpu_y     = $urandom;
        res_ready = 1'($urandom);

        for (int cyc = 0; cyc <= last; cyc++) begin
            if (cyc > 0) begin
                // Requests while busy carry junk and must not be captured.
                req_valid = 1'b1;
                req_funct = 5'($urandom);
                req_x1    = $urandom;
                req_x2    = $urandom;
                req_tag   = 6'($urandom);
                fpu_idle  = (cyc > idle_lo);
                if (exp_en < 0 || cyc <= exp_en) begin
                    fpu_valid = 1'($urandom);
                    fpu_y     = $urandom;
                end else if (cyc == exp_en + lat) begin
                    fpu_valid = 1'b1;
                    fpu_y     = y;
                end else if (cyc == exp_en + lat + 1) begin
                    fpu_valid = 1'b1;
                    fpu_y     = ~y;
                end else begin
                    fpu_valid = 1'b0;
                    fpu_y     = $urandom;
                end
                res_ready = (cyc < exp_done) ? 1'($urandom) : (cyc >= last);
            end

            @(negedge clk);
            check("req_ready", 32'(req_ready), 32'(cyc == 0));
            check("fpu_en", 32'(fpu_en), 32'(cyc == exp_en));
            check("res_valid", 32'(res_valid), 32'(cyc >= exp_done));
            if (cyc >= 1 && cyc < exp_done) begin
                check("fpu_funct", 32'(fpu_funct), 32'(f));
                check("fpu_x1", fpu_x1, a);
                check("fpu_x2", fpu_x2, b);
            end
            if (cyc >= exp_done) begin
                check("res_data", res_data, exp_d);
                check("res_tag", 32'(res_tag), 32'(t));
                check("res_err", 32'(res_err), 32'(exp_e));
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        fpu_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        check({pfx, "_fpu_en"},    32'(fpu_en),    32'd0);
        check({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
        check({pfx, "_res_err"},   32'(res_err),   32'd0);
        check({pfx, "_res_data"},  res_data,       32'd0);
        check({pfx, "_res_tag"},   32'(res_tag),   32'd0);
        check({pfx, "_fpu_funct"}, 32'(fpu_funct), 32'd0);
        check({pfx, "_fpu_x1"},    fpu_x1,         32'd0);
        check({pfx, "_fpu_x2"},    fpu_x2,         32'd0);
    endtask

    // Reset asserted while waiting for the fpu; the late result must be dropped.
    task automatic reset_in_wait();
        req_valid = 1'b1;
        req_funct = 5'b00011;
        req_x1    = 32'h4040_0000;
        req_x2    = 32'h4080_0000;
        req_tag   = 6'h2A;
        fpu_idle  = 1'b1;
        fpu_valid = 1'b0;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_en_pulse", 32'(fpu_en), 32'd1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        fpu_valid = 1'b1;
        fpu_y     = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_req_ready", 32'(req_ready), 32'd1);
            check("rst_fpu_en", 32'(fpu_en), 32'd0);
            @(posedge clk);
            #1;
            fpu_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_funct = '0;
        req_x1    = '0;
        req_x2    = '0;
        req_tag   = '0;
        fpu_y     = '0;
        fpu_valid = 1'b0;
        fpu_idle  = 1'b1;
        res_ready = 1'b0;
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // fadd 1.0 + 2.0, fpu answers 2 cycles after en: result at cycle 4.
        run_op(5'b00001, 32'h3F80_0000, 32'h4000_0000, 6'h15, 0, 2, 0);
        // fpu busy for 5 cycles after the handshake.
        run_op(5'b00011, 32'h4120_0000, 32'hC000_0000, 6'h03, 5, 1, 0);
        // writeback stalls 10 cycles with junk requests offered throughout.
        run_op(5'b00010, 32'h1234_5678, 32'h8765_4321, 6'h3F, 0, 3, 10);
        // compare codes: unsupported by default, local with the macro.
        run_op(5'b10000, 32'h8000_0000, 32'h0000_0000, 6'h11, 0, 1, 0);
        run_op(5'b10001, 32'hBF80_0000, 32'h3F80_0000, 6'h22, 0, 1, 2);
        run_op(5'b10001, 32'h3F80_0000, 32'hBF80_0000, 6'h23, 0, 1, 0);
        // all-zero function code is always unsupported.
        run_op(5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 6'h01, 2, 1, 1);
        // unsupported 1000x pattern also with other high codes that are legal.
        run_op(5'b11000, 32'h0000_0010, 32'h0000_0020, 6'h05, 1, 4, 0);

        reset_in_wait();
        run_op(5'b00100, 32'h4100_0000, 32'h4000_0000, 6'h0C, 0, 2, 1);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 3);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) begin
                f = {4'b1000, 1'($urandom)};
                case ($urandom_range(0, 3))
                    0:       b = a;
                    1:       begin a = {1'($urandom), 31'd0}; b = {~a[31], 31'd0}; end
                    2:       b = {~a[31], a[30:0]};
                    default: ;
                endcase
            end else if (sel == 1) begin
                f = 5'($urandom);
            end else begin
                f = 5'($urandom_range(1, 15));
            end
            run_op(f, a, b, 6'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                   $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
